// File: rtl/bloom_filter_unit.sv
// Multi-channel Bloom filter: NUM_FILTERS independent M_BITS-bit filters, K_HASH hashes
// applied one per cycle, with INSERT / CHECK / CLEAR / COUNT behind a valid/ready request.
module bloom_filter_unit #(
  parameter int M_BITS      = 1024,
  parameter int K_HASH      = 3,
  parameter int NUM_FILTERS = 2,
  localparam int SEL_W      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [SEL_W-1:0] req_sel_i,
  input  logic [31:0]      req_data_i,
  output logic             resp_valid_o,
  output logic [31:0]      resp_data_o,
  output logic             resp_err_o
);

  localparam int HW = $clog2(M_BITS);
  localparam int NW = M_BITS / 32;
  localparam int CW = (NW > 8) ? $clog2(NW) : 3;

  localparam logic [1:0] OP_INSERT = 2'b00;
  localparam logic [1:0] OP_CHECK  = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_COUNT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_HASH, S_CLR, S_RESP} state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [SEL_W-1:0]   sel_q;
  logic [31:0]        key_q;
  logic [CW-1:0]      step_q;
  logic               hit_q;
  logic               err_q;
  logic               resp_valid_q;
  logic [31:0]        resp_data_q;
  logic               resp_err_q;
  logic [M_BITS-1:0]  bits_q [NUM_FILTERS];
  logic [31:0]        cnt_q  [NUM_FILTERS];
  logic [HW-1:0]      h_idx;
  logic               err_d;

  function automatic logic [HW-1:0] hash_f(input logic [31:0] key, input logic [31:0] i);
    logic [31:0] seed;
    logic [31:0] x;
    logic [15:0] f;
    seed = 32'h9E3779B9 * (i + 32'd1);
    x    = key ^ seed;
    f    = x[31:16] ^ x[15:0];
    return f[HW-1:0];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    h_idx = hash_f(key_q, 32'(step_q));
    err_d = (int'(req_sel_i) >= NUM_FILTERS);
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      sel_q        <= '0;
      key_q        <= '0;
      step_q       <= '0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      for (int f = 0; f < NUM_FILTERS; f++) begin
        bits_q[f] <= '0;
        cnt_q[f]  <= '0;
      end
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            op_q   <= req_op_i;
            sel_q  <= req_sel_i;
            key_q  <= req_data_i;
            step_q <= '0;
            hit_q  <= 1'b1;
            err_q  <= err_d;
            if (err_d || req_op_i == OP_COUNT) state_q <= S_RESP;
            else if (req_op_i == OP_CLEAR)     state_q <= S_CLR;
            else                               state_q <= S_HASH;
          end
        end
        S_HASH: begin
          // Bit reads are registered, so later hashes see bits set by earlier ones
          hit_q <= hit_q & bits_q[sel_q][h_idx];
          if (op_q == OP_INSERT) bits_q[sel_q][h_idx] <= 1'b1;
          if (step_q == CW'(K_HASH - 1)) state_q <= S_RESP;
          else                           step_q  <= step_q + 1'b1;
        end
        S_CLR: begin
          bits_q[sel_q][{step_q, 5'b0} +: 32] <= '0;
          if (step_q == CW'(NW - 1)) state_q <= S_RESP;
          else                       step_q  <= step_q + 1'b1;
        end
        S_RESP: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= err_q;
          resp_data_q  <= '0;
          if (!err_q) begin
            case (op_q)
              OP_INSERT: begin
                resp_data_q  <= {31'b0, hit_q};
                cnt_q[sel_q] <= sat_inc(cnt_q[sel_q]);
              end
              OP_CHECK: resp_data_q  <= {31'b0, hit_q};
              OP_CLEAR: cnt_q[sel_q] <= '0;
              default:  resp_data_q  <= cnt_q[sel_q];
            endcase
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bloom_filter_unit.sv
// Directed bench for bloom_filter_unit (M_BITS=1024, K_HASH=3, three filters so sel=3 is out of range).
module tb_bloom_filter_unit;

  localparam logic [1:0] OP_INSERT = 2'b00;
  localparam logic [1:0] OP_CHECK  = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_COUNT  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [1:0]  req_sel = 2'b00;
  logic [31:0] req_data = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  bloom_filter_unit #(.M_BITS(1024), .K_HASH(3), .NUM_FILTERS(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_sel_i(req_sel), .req_data_i(req_data),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_err_o(resp_err)
  );

  always #5 clk = ~clk;

  // Drives one request (caller sits #1 after a rising edge with ready high) and
  // waits for the response; lat = edges from accept to resp_valid high, -1 on timeout.
  task automatic issue(input logic [1:0] op, input logic [1:0] sel, input logic [31:0] key,
                       output logic [31:0] data, output logic err, output int lat,
                       output logic rdy_low);
    req_valid = 1'b1; req_op = op; req_sel = sel; req_data = key;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rdy_low = !req_ready;
    lat = -1; data = 32'hxxxx_xxxx; err = 1'bx;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = c; data = resp_data; err = resp_err;
        break;
      end
      if (req_ready) rdy_low = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_check_empty();
    logic [31:0] d; logic e; int l; logic rl;
    issue(OP_CHECK, 2'd0, 32'h1234_5678, d, e, l, rl);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL check_empty_data: got %h expected 0", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL check_empty_err: got %b expected 0", e); end
    checks++; if (l !== 4) begin errors++; $display("FAIL check_latency: got %0d expected 4", l); end
    checks++; if (rl !== 1'b1) begin errors++; $display("FAIL check_ready_busy: got %b expected 1", rl); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_pulse_width: got %b expected 0", resp_valid); end
  endtask

  task automatic test_insert();
    logic [31:0] d; logic e; int l; logic rl;
    issue(OP_INSERT, 2'd0, 32'h1234_5678, d, e, l, rl);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL insert_first: got %h expected 0", d); end
    checks++; if (l !== 4) begin errors++; $display("FAIL insert_latency: got %0d expected 4", l); end
    issue(OP_INSERT, 2'd0, 32'h1234_5678, d, e, l, rl);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL insert_repeat: got %h expected 1", d); end
    issue(OP_CHECK, 2'd0, 32'h1234_5678, d, e, l, rl);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL check_present: got %h expected 1", d); end
    issue(OP_COUNT, 2'd0, 32'h0, d, e, l, rl);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL count_two: got %h expected 2", d); end
    checks++; if (l !== 1) begin errors++; $display("FAIL count_latency: got %0d expected 1", l); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL count_err: got %b expected 0", e); end
  endtask

  task automatic test_isolation();
    logic [31:0] d; logic e; int l; logic rl;
    issue(OP_INSERT, 2'd0, 32'hDEAD_BEEF, d, e, l, rl);
    issue(OP_CHECK, 2'd1, 32'hDEAD_BEEF, d, e, l, rl);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL iso_check_sel1: got %h expected 0", d); end
    issue(OP_COUNT, 2'd1, 32'h0, d, e, l, rl);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL iso_count_sel1: got %h expected 0", d); end
    issue(OP_COUNT, 2'd0, 32'h0, d, e, l, rl);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL iso_count_sel0: got %h expected 3", d); end
  endtask

  task automatic test_clear();
    logic [31:0] d; logic e; int l; logic rl;
    issue(OP_CLEAR, 2'd0, 32'h0, d, e, l, rl);
    checks++; if (l !== 33) begin errors++; $display("FAIL clear_latency: got %0d expected 33", l); end
    checks++; if (rl !== 1'b1) begin errors++; $display("FAIL clear_ready_low: got %b expected 1", rl); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_data: got %h expected 0", d); end
    issue(OP_CHECK, 2'd0, 32'h1234_5678, d, e, l, rl);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_check: got %h expected 0", d); end
    issue(OP_COUNT, 2'd0, 32'h0, d, e, l, rl);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_count: got %h expected 0", d); end
  endtask

  task automatic test_bad_sel();
    logic [31:0] d; logic e; int l; logic rl;
    issue(OP_INSERT, 2'd0, 32'h1234_5678, d, e, l, rl);
    issue(OP_INSERT, 2'd3, 32'h1234_5678, d, e, l, rl);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL badsel_err: got %b expected 1", e); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL badsel_data: got %h expected 0", d); end
    checks++; if (l !== 1) begin errors++; $display("FAIL badsel_latency: got %0d expected 1", l); end
    issue(OP_CLEAR, 2'd3, 32'h0, d, e, l, rl);
    checks++; if (e !== 1'b1 || l !== 1) begin errors++; $display("FAIL badsel_clear: got err=%b lat=%0d expected err=1 lat=1", e, l); end
    issue(OP_CHECK, 2'd0, 32'h1234_5678, d, e, l, rl);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL badsel_filter_kept: got %h expected 1", d); end
    issue(OP_COUNT, 2'd0, 32'h0, d, e, l, rl);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL badsel_count_kept: got %h expected 1", d); end
  endtask

  task automatic test_reset_mid(input logic [1:0] op, input logic [1:0] sel, input int wait_cyc,
                                input logic [31:0] key);
    logic [31:0] d; logic e; int l; logic rl;
    int pulses;
    pulses = 0;
    issue(OP_INSERT, sel, key, d, e, l, rl);
    req_valid = 1'b1; req_op = op; req_sel = sel; req_data = key;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < wait_cyc; c++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_no_resp: got %0d pulses expected 0", pulses); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", req_ready); end
    issue(OP_COUNT, sel, 32'h0, d, e, l, rl);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_count: got %h expected 0", d); end
    issue(OP_CHECK, sel, key, d, e, l, rl);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_check: got %h expected 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int l; logic rl;
    issue(OP_INSERT, 2'd2, 32'h0000_0001, d, e, l, rl);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", req_ready); end
    issue(OP_CHECK, 2'd2, 32'h0000_0001, d, e, l, rl);
    checks++; if (d !== 32'h1 || l !== 4) begin errors++; $display("FAIL b2b_check: got data=%h lat=%0d expected data=1 lat=4", d, l); end
    issue(OP_COUNT, 2'd2, 32'h0, d, e, l, rl);
    checks++; if (d !== 32'd1 || l !== 1) begin errors++; $display("FAIL b2b_count: got data=%h lat=%0d expected data=1 lat=1", d, l); end
  endtask

  initial begin
    test_reset();
    test_check_empty();
    test_insert();
    test_isolation();
    test_clear();
    test_bad_sel();
    test_reset_mid(OP_CLEAR, 2'd1, 5, 32'hCAFE_F00D);
    test_reset_mid(OP_INSERT, 2'd0, 1, 32'h0BAD_F00D);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
